// File: rtl/gshare_pht_updater.sv
// Write-side updater for the gshare PHT: buffers branch resolutions, performs a
// saturating read-modify-write with forwarding from recent writes, one write per cycle.
module gshare_pht_updater #(
    parameter int PC_WIDTH   = 32,
    parameter int ENT_SEL    = 10,
    parameter int DATA_WIDTH = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int HIST_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_upd_valid,
    output logic                  o_upd_ready,
    input  logic [PC_WIDTH-1:0]   i_upd_pc,
    input  logic [ENT_SEL-1:0]    i_upd_ghr,
    input  logic [DATA_WIDTH-1:0] i_upd_cnt,
    input  logic                  i_upd_taken,
    input  logic                  i_hold,
    output logic                  o_wr_en,
    output logic [ENT_SEL-1:0]    o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_idle
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic [ENT_SEL-1:0]    idx;
        logic [DATA_WIDTH-1:0] cnt;
        logic                  taken;
    } fifo_ent_t;

    fifo_ent_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  hist_vld_q  [HIST_DEPTH];
    logic                  hist_vld_d  [HIST_DEPTH];
    logic [ENT_SEL-1:0]    hist_idx_q  [HIST_DEPTH];
    logic [ENT_SEL-1:0]    hist_idx_d  [HIST_DEPTH];
    logic [DATA_WIDTH-1:0] hist_data_q [HIST_DEPTH];
    logic [DATA_WIDTH-1:0] hist_data_d [HIST_DEPTH];

    logic                  wr_en_q, wr_en_d;
    logic [ENT_SEL-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                  push;
    logic                  pop;
    fifo_ent_t             enq_ent;
    fifo_ent_t             head_ent;
    logic [DATA_WIDTH-1:0] base_cnt;
    logic [DATA_WIDTH-1:0] new_cnt;
    logic                  unused_pc;

    assign o_upd_ready = (count_q != FULL_CNT);
    assign push        = i_upd_valid && o_upd_ready;
    assign pop         = (count_q != '0) && !i_hold;
    assign enq_ent     = {i_upd_pc[ENT_SEL+1:2] ^ i_upd_ghr, i_upd_cnt, i_upd_taken};
    assign head_ent    = fifo_q[rd_ptr_q];
    assign unused_pc   = ^{i_upd_pc[PC_WIDTH-1:ENT_SEL+2], i_upd_pc[1:0]};

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_idle    = (count_q == '0) && !wr_en_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Walk history oldest to youngest so younger matches override; the
    // in-flight output register is younger than every history entry.
    always_comb begin
        base_cnt = head_ent.cnt;
        for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
            if (hist_vld_q[i] && (hist_idx_q[i] == head_ent.idx)) begin
                base_cnt = hist_data_q[i];
            end
        end
        if (wr_en_q && (wr_addr_q == head_ent.idx)) begin
            base_cnt = wr_data_q;
        end
        new_cnt = base_cnt;
        if (head_ent.taken) begin
            if (base_cnt != CNT_MAX) new_cnt = base_cnt + DATA_WIDTH'(1);
        end else begin
            if (base_cnt != '0) new_cnt = base_cnt - DATA_WIDTH'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_vld_d[i]  = hist_vld_q[i];
            hist_idx_d[i]  = hist_idx_q[i];
            hist_data_d[i] = hist_data_q[i];
        end
        if (pop) begin
            hist_vld_d[0]  = 1'b1;
            hist_idx_d[0]  = head_ent.idx;
            hist_data_d[0] = new_cnt;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist_vld_d[i]  = hist_vld_q[i-1];
                hist_idx_d[i]  = hist_idx_q[i-1];
                hist_data_d[i] = hist_data_q[i-1];
            end
        end
    end

    always_comb begin
        wr_en_d   = pop;
        wr_addr_d = pop ? head_ent.idx : wr_addr_q;
        wr_data_d = pop ? new_cnt      : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q] <= enq_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_vld_q[i]  <= 1'b0;
                hist_idx_q[i]  <= '0;
                hist_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_vld_q[i]  <= hist_vld_d[i];
                hist_idx_q[i]  <= hist_idx_d[i];
                hist_data_q[i] <= hist_data_d[i];
            end
        end
    end
endmodule

// File: tb/tb_gshare_pht_updater.sv
// Randomised bench for gshare_pht_updater: a queue-based model of the last four
// issued writes predicts every PHT write from the accepted resolution stream.
module tb_gshare_pht_updater;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_upd_valid = 1'b0;
    logic        o_upd_ready;
    logic [31:0] i_upd_pc = '0;
    logic [9:0]  i_upd_ghr = '0;
    logic [1:0]  i_upd_cnt = '0;
    logic        i_upd_taken = 1'b0;
    logic        i_hold = 1'b0;
    logic        o_wr_en;
    logic [9:0]  o_wr_addr;
    logic [1:0]  o_wr_data;
    logic        o_idle;

    gshare_pht_updater dut (
        .clk(clk), .rst(rst),
        .i_upd_valid(i_upd_valid), .o_upd_ready(o_upd_ready),
        .i_upd_pc(i_upd_pc), .i_upd_ghr(i_upd_ghr), .i_upd_cnt(i_upd_cnt),
        .i_upd_taken(i_upd_taken), .i_hold(i_hold),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_idle(o_idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic [1:0] data;
        int         cyc;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  obs_q[$];
    wr_t  exp_q[$];
    logic [9:0] hist_idx[$];
    logic [1:0] hist_dat[$];
    logic acc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_wr_en === 1'b1) begin
            obs_q.push_back('{addr: o_wr_addr, data: o_wr_data, cyc: cyc});
            $display("write addr=%h data=%0d cycle=%0d", o_wr_addr, o_wr_data, cyc);
        end
    end

    // Reference: counter of the youngest of the last four writes to this index,
    // else the prediction-time snapshot, then saturating +/-1.
    task automatic model_accept(input logic [9:0] idx, input logic [1:0] cnt, input logic tk);
        int base = cnt;
        int nv;
        for (int j = 0; j < hist_idx.size(); j++) begin
            if (hist_idx[j] == idx) begin
                base = hist_dat[j];
                break;
            end
        end
        nv = tk ? ((base == 3) ? 3 : base + 1) : ((base == 0) ? 0 : base - 1);
        exp_q.push_back('{addr: idx, data: nv[1:0], cyc: 0});
        hist_idx.push_front(idx);
        hist_dat.push_front(nv[1:0]);
        if (hist_idx.size() > 4) begin
            void'(hist_idx.pop_back());
            void'(hist_dat.pop_back());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [9:0] ghr,
                         input logic [1:0] cnt, input logic tk, input logic hold,
                         output logic accepted);
        i_upd_valid = v;
        i_upd_pc    = pc;
        i_upd_ghr   = ghr;
        i_upd_cnt   = cnt;
        i_upd_taken = tk;
        i_hold      = hold;
        accepted    = v && (o_upd_ready === 1'b1) && !rst;
        if (accepted) model_accept(pc[11:2] ^ ghr, cnt, tk);
        $display("cycle=%0d valid=%0b hold=%0b rst=%0b pc=%h ghr=%h cnt=%0d taken=%0b accepted=%0b",
                 cyc, v, hold, rst, pc, ghr, cnt, tk, accepted);
        tick();
        i_upd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_upd_valid = 1'b0;
        i_hold      = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_drain(input string name, input int bound);
        i_upd_valid = 1'b0;
        i_hold      = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (o_idle === 1'b1 && obs_q.size() >= exp_q.size()) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s_drain: got %0d writes idle=%b, expected %0d writes and idle=1",
                 name, obs_q.size(), o_idle, exp_q.size());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 10'($urandom), 2'($urandom), 1'b1, 1'b0, acc);
        rst = 1'b0;
        checks += 5;
        if (o_upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_upd_ready); end
        if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", o_idle); end
        if (o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", o_wr_en); end
        if (o_wr_addr !== 10'h0) begin errors++; $display("FAIL reset_addr: got %h expected 000", o_wr_addr); end
        if (o_wr_data !== 2'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", o_wr_data); end
        idle(4);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL reset_dropped: got %0d writes expected 0", obs_q.size()); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single();
        int c0;
        drive(1'b1, 32'h0000_0010, 10'h001, 2'd1, 1'b1, 1'b0, acc);
        c0 = cyc;
        wait_drain("single", 10);
        idle(2);
        checks += 6;
        if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b expected 1", acc); end
        if (obs_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d writes expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            if (obs_q[0].addr !== 10'h005) begin errors++; $display("FAIL single_addr: got %h expected 005", obs_q[0].addr); end
            if (obs_q[0].data !== 2'd2) begin errors++; $display("FAIL single_data: got %0d expected 2", obs_q[0].data); end
            if (obs_q[0].cyc != c0 + 1) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", obs_q[0].cyc, c0 + 1); end
        end else errors += 3;
        if (o_idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b expected 1", o_idle); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_saturation();
        logic [1:0] cnts [3];
        logic       tks  [3];
        logic [1:0] want [3];
        cnts = '{2'd3, 2'd0, 2'd2};
        tks  = '{1'b1, 1'b0, 1'b0};
        want = '{2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 3; k++) drive(1'b1, 32'(10'h100 + k) << 2, 10'h000, cnts[k], tks[k], 1'b0, acc);
        wait_drain("sat", 12);
        checks++;
        if (obs_q.size() != 3) begin errors++; $display("FAIL sat_count: got %0d expected 3", obs_q.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_q[k].addr !== 10'(10'h100 + k) || obs_q[k].data !== want[k]) begin
                errors++;
                $display("FAIL sat_write%0d: got addr=%h data=%0d expected addr=%h data=%0d",
                         k, obs_q[k].addr, obs_q[k].data, 10'(10'h100 + k), want[k]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_forwarding();
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h3A0 << 2, 10'h000, 2'd0, 1'b1, 1'b0, acc);
        wait_drain("fwd", 12);
        checks++;
        if (obs_q.size() != 3) begin errors++; $display("FAIL fwd_count: got %0d expected 3", obs_q.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_q[k].addr !== 10'h3A0 || obs_q[k].data !== 2'(k + 1) || obs_q[k].cyc != obs_q[0].cyc + k) begin
                errors++;
                $display("FAIL fwd_chain%0d: got addr=%h data=%0d cycle=%0d expected addr=3a0 data=%0d cycle=%0d",
                         k, obs_q[k].addr, obs_q[k].data, obs_q[k].cyc, k + 1, obs_q[0].cyc + k);
            end
        end
        obs_q.delete();
        exp_q.delete();
        for (int k = 1; k <= 5; k++) drive(1'b1, 32'(10'h3A0 + k) << 2, 10'h000, 2'($urandom), 1'($urandom), 1'b0, acc);
        drive(1'b1, 32'h3A0 << 2, 10'h000, 2'd0, 1'b1, 1'b0, acc);
        wait_drain("fwd_age", 20);
        checks++;
        if (obs_q.size() != 6 || obs_q[5].addr !== 10'h3A0 || obs_q[5].data !== 2'd1) begin
            errors++;
            $display("FAIL fwd_aged: got %0d writes last addr=%h data=%0d expected 6 writes last addr=3a0 data=1",
                     obs_q.size(), obs_q[obs_q.size() > 0 ? obs_q.size() - 1 : 0].addr,
                     obs_q[obs_q.size() > 0 ? obs_q.size() - 1 : 0].data);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_q[k].addr !== exp_q[k].addr || obs_q[k].data !== exp_q[k].data) begin
                errors++;
                $display("FAIL fwd_other%0d: got addr=%h data=%0d expected addr=%h data=%0d",
                         k, obs_q[k].addr, obs_q[k].data, exp_q[k].addr, exp_q[k].data);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] pc [5];
        logic [1:0]  cn [5];
        logic        tk [5];
        int          n = 0;
        for (int k = 0; k < 5; k++) begin
            pc[k] = $urandom;
            cn[k] = 2'($urandom);
            tk[k] = 1'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, pc[k], 10'h0, cn[k], tk[k], 1'b1, acc);
            if (acc) n++;
        end
        checks += 2;
        if (n != 4) begin errors++; $display("FAIL bp_fill: got %0d accepts expected 4", n); end
        if (o_upd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", o_upd_ready); end
        drive(1'b1, pc[4], 10'h0, cn[4], tk[4], 1'b1, acc);
        drive(1'b1, pc[4], 10'h0, cn[4], tk[4], 1'b1, acc);
        checks += 2;
        if (acc !== 1'b0) begin errors++; $display("FAIL bp_refused: got accept=%b expected 0", acc); end
        if (obs_q.size() != 0) begin errors++; $display("FAIL bp_held: got %0d writes expected 0", obs_q.size()); end
        acc = 1'b0;
        for (int t = 0; t < 6 && !acc; t++) drive(1'b1, pc[4], 10'h0, cn[4], tk[4], 1'b0, acc);
        wait_drain("bp", 20);
        checks++;
        if (obs_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", obs_q.size()); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_q[k].addr !== exp_q[k].addr || obs_q[k].data !== exp_q[k].data ||
                (k < 4 && obs_q[k].cyc != obs_q[0].cyc + k)) begin
                errors++;
                $display("FAIL bp_write%0d: got addr=%h data=%0d cycle=%0d expected addr=%h data=%0d",
                         k, obs_q[k].addr, obs_q[k].data, obs_q[k].cyc, exp_q[k].addr, exp_q[k].data);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_push_pop();
        for (int k = 0; k < 3; k++) drive(1'b1, $urandom, 10'($urandom), 2'($urandom), 1'($urandom), 1'b1, acc);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (o_upd_ready !== 1'b1 || o_idle !== 1'b0) begin
                errors++;
                $display("FAIL pp_ready%0d: got ready=%b idle=%b expected ready=1 idle=0", k, o_upd_ready, o_idle);
            end
            drive(1'b1, $urandom, 10'($urandom), 2'($urandom), 1'($urandom), 1'b0, acc);
        end
        wait_drain("pp", 20);
        checks++;
        if (obs_q.size() != 13) begin errors++; $display("FAIL pp_count: got %0d expected 13", obs_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k].addr !== exp_q[k].addr || obs_q[k].data !== exp_q[k].data) begin
                errors++;
                $display("FAIL pp_write%0d: got addr=%h data=%0d expected addr=%h data=%0d",
                         k, obs_q[k].addr, obs_q[k].data, exp_q[k].addr, exp_q[k].data);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int k = 0; k < 120; k++) begin
            pc = $urandom;
            drive($urandom_range(0, 3) != 0, pc, pc[11:2] ^ 10'($urandom_range(0, 7)),
                  2'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, acc);
        end
        wait_drain("rand", 40);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k].addr !== exp_q[k].addr || obs_q[k].data !== exp_q[k].data) begin
                errors++;
                $display("FAIL rand_write%0d: got addr=%h data=%0d expected addr=%h data=%0d",
                         k, obs_q[k].addr, obs_q[k].data, exp_q[k].addr, exp_q[k].data);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h055 << 2, 10'h0, 2'd0, 1'b1, 1'b1, acc);
        drive(1'b0, 32'h0, 10'h0, 2'd0, 1'b0, 1'b0, acc);
        checks++;
        if (o_wr_en !== 1'b1) begin errors++; $display("FAIL mid_inflight: got wr_en=%b expected 1", o_wr_en); end
        rst = 1'b1;
        drive(1'b1, 32'h055 << 2, 10'h0, 2'd0, 1'b1, 1'b0, acc);
        rst = 1'b0;
        checks += 2;
        if (o_wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en: got %b expected 0", o_wr_en); end
        if (o_idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b expected 1", o_idle); end
        idle(6);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].addr !== exp_q[0].addr || obs_q[0].data !== exp_q[0].data) begin
            errors++;
            $display("FAIL mid_writes: got %0d writes first addr=%h data=%0d expected 1 write addr=%h data=%0d",
                     obs_q.size(), obs_q[0].addr, obs_q[0].data, exp_q[0].addr, exp_q[0].data);
        end
        obs_q.delete();
        exp_q.delete();
        hist_idx.delete();
        hist_dat.delete();
        drive(1'b1, 32'h055 << 2, 10'h0, 2'd0, 1'b1, 1'b0, acc);
        wait_drain("mid_post", 10);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].addr !== 10'h055 || obs_q[0].data !== 2'd1) begin
            errors++;
            $display("FAIL mid_no_forward: got %0d writes addr=%h data=%0d expected 1 write addr=055 data=1",
                     obs_q.size(), obs_q[0].addr, obs_q[0].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_forwarding();
        test_backpressure();
        test_push_pop();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
